// File: rtl/tick_gen_pkg.sv
// Shared types, constants and helpers for the tick generator timebase.
package tick_gen_pkg;

  localparam int DEFAULT_CNT_W    = 16;
  localparam int FAST_SIM_PRE_DIV = 4;

  typedef logic [DEFAULT_CNT_W-1:0] ratio_t;

  function automatic int pre_div(input int clk_hz, input int base_hz);
    return clk_hz / base_hz;
  endfunction

endpackage

// File: rtl/tick_generator_if.sv
// Control and pulse-output bundle of the tick generator.
interface tick_generator_if
  import tick_gen_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = DEFAULT_CNT_W
);

  logic                    en;
  logic                    sync_clr;
  logic [NUM_CH*CNT_W-1:0] ch_div;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       square;
  logic                    base_tick;

  modport master (
    output en, sync_clr, ch_div,
    input  tick, square, base_tick
  );

  modport slave (
    input  en, sync_clr, ch_div,
    output tick, square, base_tick
  );

endinterface

// File: rtl/tick_channel.sv
// One divider channel: counts base-tick events against a shadowed ratio and
// produces a registered tick pulse plus a square wave toggling on each tick.
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             base_evt,
  input  logic             sync_clr,
  input  logic [CNT_W-1:0] ratio,
  output logic             tick,
  output logic             square
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             tick_q, tick_d;
  logic             square_q, square_d;

  // A zero shadow means disabled; it keeps reloading so a new ratio is picked up immediately.
  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    tick_d   = 1'b0;
    square_d = square_q;
    if (sync_clr) begin
      cnt_d    = '0;
      shadow_d = ratio;
      square_d = 1'b0;
    end else if (shadow_q == '0) begin
      cnt_d    = '0;
      shadow_d = ratio;
    end else if (base_evt) begin
      if (cnt_q == shadow_q - CNT_W'(1)) begin
        cnt_d    = '0;
        shadow_d = ratio;
        tick_d   = 1'b1;
        square_d = ~square_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      tick_q   <= 1'b0;
      square_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      tick_q   <= tick_d;
      square_q <= square_d;
    end
  end

  assign tick   = tick_q;
  assign square = square_q;

endmodule

// File: rtl/tick_generator.sv
// Multi-channel timebase: shared prescaler to BASE_HZ feeding NUM_CH divider channels.
// Define TICK_GEN_FAST_SIM_EN to force the prescaler ratio to FAST_SIM_PRE_DIV for short sims.
module tick_generator
  import tick_gen_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BASE_HZ = 1_000,
  parameter int NUM_CH  = 3,
  parameter int CNT_W   = $bits(ratio_t)
) (
  input  logic             clk,
  input  logic             reset,
  tick_generator_if.slave  bus
);

`ifdef TICK_GEN_FAST_SIM_EN
  localparam int PRE_DIV = FAST_SIM_PRE_DIV;
`else
  localparam int PRE_DIV = pre_div(CLK_HZ, BASE_HZ);
`endif
  localparam int PRE_W = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;

  if (BASE_HZ <= 0 || (CLK_HZ % BASE_HZ) != 0) begin : g_bad_clk_ratio
    $error("tick_generator: CLK_HZ must be an exact multiple of BASE_HZ");
  end
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("tick_generator: NUM_CH must be in 1..8");
  end

  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic              base_tick_q, base_tick_d;
  logic              pre_wrap;
  logic              out_en;
  logic [NUM_CH-1:0] tick_raw;
  logic [NUM_CH-1:0] square_raw;

  assign pre_wrap = bus.en && !bus.sync_clr && (pre_cnt_q == PRE_W'(PRE_DIV - 1));

  always_comb begin
    pre_cnt_d   = pre_cnt_q;
    base_tick_d = 1'b0;
    if (bus.sync_clr) begin
      pre_cnt_d = '0;
    end else if (pre_wrap) begin
      pre_cnt_d   = '0;
      base_tick_d = 1'b1;
    end else if (bus.en) begin
      pre_cnt_d = pre_cnt_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt_q   <= '0;
      base_tick_q <= 1'b0;
    end else begin
      pre_cnt_q   <= pre_cnt_d;
      base_tick_q <= base_tick_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_channel #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .base_evt (pre_wrap),
      .sync_clr (bus.sync_clr),
      .ratio    (bus.ch_div[i*CNT_W +: CNT_W]),
      .tick     (tick_raw[i]),
      .square   (square_raw[i])
    );
  end

  // Pulses are suppressed outright while frozen or being cleared, even if already registered.
  assign out_en        = bus.en && !bus.sync_clr;
  assign bus.tick      = tick_raw & {NUM_CH{out_en}};
  assign bus.base_tick = base_tick_q & out_en;
  assign bus.square    = square_raw;

endmodule
